instfetch: RTL and testbench

Instruction fetch unit for the RV32I core: it owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents one instruction at a time to the decode stage over a valid/ready handshake. It also accepts PC redirects from branch/jump resolution and flags misaligned targets. Its output drives the decoder's `instruction` input directly.

---
 rtl/instfetch.sv | 105 ++++++++++
 tb/tb_instfetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instfetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack memory
// handshake and presents one instruction at a time to decode over valid/ready.
module instfetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        ivalid,
  input  logic        iready,
  output logic [31:0] pc_out,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [31:0] RESET_PCA = {RESET_PC[31:2], 2'b00};

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc_out_r, pc_out_s;

  // Next-state logic; a redirect overrides every handshake in the same cycle.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    instr_s  = instr_r;
    pc_out_s = pc_out_r;
    if (redirect) begin
      if (redirect_pc[1:0] == 2'b00) begin
        pc_s    = redirect_pc;
        state_s = FETCH;
      end else begin
        pc_out_s = redirect_pc;
        state_s  = FAULT;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_s  = imem_rdata;
            pc_out_s = pc_r;
            pc_s     = pc_r + 32'd4;
            state_s  = HOLD;
          end else begin
            state_s = FETCH;
          end
        end
        HOLD: begin
          if (iready) begin
            state_s = FETCH;
          end else begin
            state_s = HOLD;
          end
        end
        FAULT: begin
          state_s = FAULT;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, PC and presented-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      pc_r     <= RESET_PCA;
      instr_r  <= NOP_INSN;
      pc_out_r <= RESET_PCA;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      pc_out_r <= pc_out_s;
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign imem_req    = (state_r == FETCH);
  assign ivalid      = (state_r == HOLD);
  assign fault       = (state_r == FAULT);
  assign imem_addr   = pc_r;
  assign instruction = instr_r;
  assign pc_out      = pc_out_r;

endmodule

// File: tb/tb_instfetch.sv
// Self-checking bench for instfetch: directed scenarios plus a randomized run
// checked against a transaction-level model of the presented instruction stream.
module tb_instfetch;

  logic        clk;
  logic        rst, imem_ack, iready, redirect;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, ivalid, fault;
  logic [31:0] imem_addr, instruction, pc_out;

  logic        rst_w, imem_ack_w, iready_w, redirect_w;
  logic [31:0] redirect_pc_w, imem_rdata_w;
  logic        imem_req_w, ivalid_w, fault_w;
  logic [31:0] imem_addr_w, instruction_w, pc_out_w;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata   = memf(imem_addr);
  assign imem_rdata_w = memf(imem_addr_w);

  instfetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .ivalid(ivalid), .iready(iready), .pc_out(pc_out), .redirect(redirect),
    .redirect_pc(redirect_pc), .fault(fault)
  );

  instfetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .instruction(instruction_w),
    .ivalid(ivalid_w), .iready(iready_w), .pc_out(pc_out_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .fault(fault_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_ack = 1'b1; iready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    step(); step();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_checks++; if (ivalid !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid got=%b exp=0", ivalid); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault got=%b exp=0", fault); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr got=%h exp=00000100", imem_addr); end
    n_checks++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL rst_pc_out got=%h exp=00000100", pc_out); end
    n_checks++; if (instruction !== 32'h13) begin n_fail++; $display("FAIL rst_insn got=%h exp=00000013", instruction); end
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'h100 + 32'(4 * k);
      n_checks++; if (ivalid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a) begin
        n_fail++; $display("FAIL seq_fetch k=%0d got req=%b v=%b addr=%h exp req=1 v=0 addr=%h", k, imem_req, ivalid, imem_addr, a);
      end
      step();
      n_checks++; if (ivalid !== 1'b1 || imem_req !== 1'b0 || pc_out !== a || instruction !== memf(a)) begin
        n_fail++; $display("FAIL seq_hold k=%0d got v=%b req=%b pc=%h insn=%h exp v=1 req=0 pc=%h insn=%h", k, ivalid, imem_req, pc_out, instruction, a, memf(a));
      end
      step();
    end
  endtask

  task automatic test_ack_delay;
    // Entering with the HOLD of 108 just consumed: now in FETCH at 10C.
    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C || ivalid !== 1'b0) begin
        n_fail++; $display("FAIL ack_wait i=%0d got req=%b addr=%h v=%b exp req=1 addr=0000010c v=0", i, imem_req, imem_addr, ivalid);
      end
      if (i == 3) imem_ack = 1'b1;
      step();
    end
    n_checks++; if (ivalid !== 1'b1 || pc_out !== 32'h10C || instruction !== memf(32'h10C)) begin
      n_fail++; $display("FAIL ack_valid got v=%b pc=%h insn=%h exp v=1 pc=0000010c insn=%h", ivalid, pc_out, instruction, memf(32'h10C));
    end
  endtask

  task automatic test_stall;
    iready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (ivalid !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h10C || instruction !== memf(32'h10C)) begin
        n_fail++; $display("FAIL stall i=%0d got v=%b req=%b pc=%h insn=%h exp v=1 req=0 pc=0000010c", i, ivalid, imem_req, pc_out, instruction);
      end
      if (i == 5) iready = 1'b1;
      step();
    end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h110 || ivalid !== 1'b0) begin
      n_fail++; $display("FAIL stall_resume got req=%b addr=%h v=%b exp req=1 addr=00000110 v=0", imem_req, imem_addr, ivalid);
    end
  endtask

  task automatic test_redirect_ack;
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || ivalid !== 1'b0 || pc_out !== 32'h10C) begin
      n_fail++; $display("FAIL redir_ack got req=%b addr=%h v=%b pc=%h exp req=1 addr=00000200 v=0 pc=0000010c", imem_req, imem_addr, ivalid, pc_out);
    end
    step();
    n_checks++; if (ivalid !== 1'b1 || pc_out !== 32'h200 || instruction !== memf(32'h200)) begin
      n_fail++; $display("FAIL redir_present got v=%b pc=%h insn=%h exp v=1 pc=00000200 insn=%h", ivalid, pc_out, instruction, memf(32'h200));
    end
  endtask

  task automatic test_fault;
    iready = 1'b1; redirect = 1'b1; redirect_pc = 32'h202;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (fault !== 1'b1 || ivalid !== 1'b0 || imem_req !== 1'b0 || pc_out !== 32'h202) begin
        n_fail++; $display("FAIL fault_hold i=%0d got f=%b v=%b req=%b pc=%h exp f=1 v=0 req=0 pc=00000202", i, fault, ivalid, imem_req, pc_out);
      end
      step();
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect = 1'b0;
    n_checks++; if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300 || ivalid !== 1'b0) begin
      n_fail++; $display("FAIL fault_clear got f=%b req=%b addr=%h v=%b exp f=0 req=1 addr=00000300 v=0", fault, imem_req, imem_addr, ivalid);
    end
    step();
    n_checks++; if (ivalid !== 1'b1 || pc_out !== 32'h300 || instruction !== memf(32'h300)) begin
      n_fail++; $display("FAIL fault_refetch got v=%b pc=%h insn=%h exp v=1 pc=00000300", ivalid, pc_out, instruction);
    end
  endtask

  task automatic test_wrap_and_reset;
    n_checks++; if (imem_req_w !== 1'b0 || ivalid_w !== 1'b0 || fault_w !== 1'b0 || imem_addr_w !== 32'hFFFF_FFFC ||
                    pc_out_w !== 32'hFFFF_FFFC || instruction_w !== 32'h13) begin
      n_fail++; $display("FAIL wrap_rst got req=%b v=%b f=%b addr=%h pc=%h insn=%h", imem_req_w, ivalid_w, fault_w, imem_addr_w, pc_out_w, instruction_w);
    end
    rst_w = 1'b0; imem_ack_w = 1'b1;
    step();
    n_checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_first got req=%b addr=%h exp req=1 addr=fffffffc", imem_req_w, imem_addr_w);
    end
    step();
    n_checks++; if (ivalid_w !== 1'b1 || pc_out_w !== 32'hFFFF_FFFC || instruction_w !== memf(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_present got v=%b pc=%h exp v=1 pc=fffffffc", ivalid_w, pc_out_w);
    end
    imem_ack_w = 1'b0;
    step(); step();
    n_checks++; if (imem_req_w !== 1'b1 || imem_addr_w !== 32'h0) begin
      n_fail++; $display("FAIL wrap_second got req=%b addr=%h exp req=1 addr=00000000", imem_req_w, imem_addr_w);
    end
    rst_w = 1'b1; imem_ack_w = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (imem_req_w !== 1'b0 || ivalid_w !== 1'b0 || fault_w !== 1'b0 || imem_addr_w !== 32'hFFFF_FFFC ||
                      pc_out_w !== 32'hFFFF_FFFC || instruction_w !== 32'h13) begin
        n_fail++; $display("FAIL wrap_midrst i=%0d got req=%b v=%b f=%b addr=%h pc=%h insn=%h", i, imem_req_w, ivalid_w, fault_w, imem_addr_w, pc_out_w, instruction_w);
      end
    end
  endtask

  task automatic test_random;
    logic        pres, flt, exp_req;
    logic [31:0] exp_next, exp_pc;
    logic [31:0] tgt;
    rst = 1'b1; redirect = 1'b0;
    step();
    rst = 1'b0;
    step();
    pres = 1'b0; flt = 1'b0; exp_next = 32'h100; exp_pc = 32'h100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      exp_req = !pres && !flt;
      n_checks++; if (imem_req !== exp_req || ivalid !== pres || fault !== flt) begin
        n_fail++; $display("FAIL rand_flags cyc=%0d got req=%b v=%b f=%b exp req=%b v=%b f=%b", cyc, imem_req, ivalid, fault, exp_req, pres, flt);
      end
      if (exp_req) begin
        n_checks++; if (imem_addr !== exp_next) begin
          n_fail++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, exp_next);
        end
      end
      if (pres || flt) begin
        n_checks++; if (pc_out !== exp_pc || (pres && instruction !== memf(exp_pc))) begin
          n_fail++; $display("FAIL rand_out cyc=%0d got pc=%h insn=%h exp pc=%h insn=%h", cyc, pc_out, instruction, exp_pc, memf(exp_pc));
        end
      end
      imem_ack = 1'($urandom_range(0, 1));
      iready   = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      else tgt[1:0] = 2'(1 + $urandom_range(0, 2));
      redirect_pc = tgt;
      if (redirect) begin
        pres = 1'b0;
        if (tgt[1:0] == 2'b00) begin
          exp_next = tgt; flt = 1'b0;
        end else begin
          exp_pc = tgt; flt = 1'b1;
        end
      end else if (flt) begin
        flt = 1'b1;
      end else if (!pres && imem_ack) begin
        pres = 1'b1; exp_pc = exp_next; exp_next = exp_next + 32'd4;
      end else if (pres && iready) begin
        pres = 1'b0;
      end
      step();
    end
    redirect = 1'b0;
  endtask

  initial begin
    rst_w = 1'b1; imem_ack_w = 1'b1; iready_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = 32'h0;
    test_reset();
    test_ack_delay();
    test_stall();
    test_redirect_ack();
    test_fault();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
